uart_rx_fifo: RTL

Receive-side buffer directly downstream of the UART receiver. Captures each completed frame (data plus parity/stop/break flags) on the receiver's rx_done pulse and stores it in a DEPTH-entry synchronous FIFO. Presents frames to the host side through a first-word-fall-through valid/ready interface. Drives the receiver's rx_start_n enable so reception is held off while the FIFO is full or disabled.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_fifo_if.sv | 21 ++
 rtl/uart_fifo_ram.sv | 25 ++
 rtl/uart_rx_fifo.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and default sizing for the UART receive-side FIFO.
package uart_pkg;

  localparam int unsigned UART_DATA_SIZE     = 8;
  localparam int unsigned UART_RX_FIFO_DEPTH = 16;

  typedef struct packed {
    logic                      break_err;
    logic                      stop_err;
    logic                      parity_err;
    logic [UART_DATA_SIZE-1:0] data;
  } rx_entry_t;

  typedef enum logic {
    CAP_IDLE   = 1'b0,
    CAP_COMMIT = 1'b1
  } cap_state_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Host-side first-word-fall-through read handshake of the UART receive FIFO.
interface uart_rx_fifo_if #(
  parameter int unsigned DATA_SIZE = 8
);
  logic                 rd_valid;
  logic                 rd_ready;
  logic [DATA_SIZE-1:0] rd_data;
  logic                 rd_parity_error;
  logic                 rd_stop_error;
  logic                 rd_break_error;

  modport master (
    output rd_valid, rd_data, rd_parity_error, rd_stop_error, rd_break_error,
    input  rd_ready
  );

  modport slave (
    input  rd_valid, rd_data, rd_parity_error, rd_stop_error, rd_break_error,
    output rd_ready
  );
endinterface

// File: rtl/uart_fifo_ram.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH     = UART_RX_FIFO_DEPTH,
  parameter int unsigned ADDR_SIZE = $clog2(DEPTH),
  parameter type         T         = rx_entry_t
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [ADDR_SIZE-1:0] i_waddr,
  input  T                     i_wdata,
  input  logic [ADDR_SIZE-1:0] i_raddr,
  output T                     o_rdata
);

  T r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: frame capture FSM, FWFT read port, overrun and rx_start_n control.
// Optional UART_RX_FIFO_DROP_ERR_EN: errored frames are discarded and counted in drop_count.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_SIZE = UART_DATA_SIZE,
  parameter int unsigned DEPTH     = UART_RX_FIFO_DEPTH,
  parameter int unsigned ADDR_SIZE = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_enable,
  input  logic                 rx_done,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic                 parity_error_in,
  input  logic                 stop_error_in,
  input  logic                 break_error_in,
  output logic                 rx_start_n,
  uart_rx_fifo_if.master       rd,
  output logic [ADDR_SIZE:0]   count,
  output logic                 full,
  output logic                 empty,
  output logic                 overrun,
  input  logic                 overrun_clr
`ifdef UART_RX_FIFO_DROP_ERR_EN
  ,
  output logic [7:0]           drop_count
`endif
);

  typedef struct packed {
    logic                 break_err;
    logic                 stop_err;
    logic                 parity_err;
    logic [DATA_SIZE-1:0] data;
  } entry_t;

  localparam logic [ADDR_SIZE:0] LP_PTR_ONE     = (ADDR_SIZE+1)'(1);
  localparam logic [ADDR_SIZE:0] LP_ALMOST_FULL = (ADDR_SIZE+1)'(DEPTH-1);

  cap_state_t         r_state, w_state_nxt;
  logic [2:0]         r_flags;
  logic [ADDR_SIZE:0] r_wptr, r_rptr;
  logic               r_overrun, r_start_n;
  logic               w_commit, w_push, w_pop, w_room, w_ovr_set;
  logic               w_full, w_empty;
  logic [ADDR_SIZE:0] w_count;
  entry_t             w_wr_entry, w_rd_entry;

  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    case (r_state)
      CAP_IDLE:   if (rx_done) w_state_nxt = CAP_COMMIT;
      CAP_COMMIT: begin
        w_commit = 1'b1;
        if (!rx_done) w_state_nxt = CAP_IDLE;
      end
      default:    w_state_nxt = CAP_IDLE;
    endcase
  end

  always_comb begin
    w_wr_entry            = '0;
    w_wr_entry.break_err  = r_flags[2];
    w_wr_entry.stop_err   = r_flags[1];
    w_wr_entry.parity_err = r_flags[0];
    w_wr_entry.data       = data_in;
  end

  assign w_count = r_wptr - r_rptr;
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[ADDR_SIZE] != r_rptr[ADDR_SIZE]) &&
                   (r_wptr[ADDR_SIZE-1:0] == r_rptr[ADDR_SIZE-1:0]);
  assign w_pop   = !w_empty && rd.rd_ready;
  // A pop in the same cycle frees the slot the full-FIFO push writes into.
  assign w_room  = !w_full || w_pop;

`ifdef UART_RX_FIFO_DROP_ERR_EN
  logic       w_err;
  logic [7:0] r_drop_count;

  assign w_err     = |r_flags;
  assign w_push    = w_commit && !w_err && w_room;
  assign w_ovr_set = w_commit && !w_err && !w_room;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_drop_count <= '0;
    else if (w_commit && w_err && (r_drop_count != '1)) r_drop_count <= r_drop_count + 8'd1;
  end

  assign drop_count = r_drop_count;
`else
  assign w_push    = w_commit && w_room;
  assign w_ovr_set = w_commit && !w_room;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= CAP_IDLE;
      r_flags   <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_overrun <= 1'b0;
      r_start_n <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (rx_done) r_flags <= {break_error_in, stop_error_in, parity_error_in};
      if (w_push)  r_wptr  <= r_wptr + LP_PTR_ONE;
      if (w_pop)   r_rptr  <= r_rptr + LP_PTR_ONE;
      if (w_ovr_set)        r_overrun <= 1'b1;
      else if (overrun_clr) r_overrun <= 1'b0;
      // Anticipate the pending commit filling the last slot.
      r_start_n <= !rx_enable || w_full ||
                   ((w_count == LP_ALMOST_FULL) && (r_state == CAP_COMMIT));
    end
  end

  uart_fifo_ram #(
    .DEPTH    (DEPTH),
    .ADDR_SIZE(ADDR_SIZE),
    .T        (entry_t)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_push),
    .i_waddr(r_wptr[ADDR_SIZE-1:0]),
    .i_wdata(w_wr_entry),
    .i_raddr(r_rptr[ADDR_SIZE-1:0]),
    .o_rdata(w_rd_entry)
  );

  assign rd.rd_valid        = !w_empty;
  assign rd.rd_data         = w_empty ? '0   : w_rd_entry.data;
  assign rd.rd_parity_error = w_empty ? 1'b0 : w_rd_entry.parity_err;
  assign rd.rd_stop_error   = w_empty ? 1'b0 : w_rd_entry.stop_err;
  assign rd.rd_break_error  = w_empty ? 1'b0 : w_rd_entry.break_err;

  assign count      = w_count;
  assign full       = w_full;
  assign empty      = w_empty;
  assign overrun    = r_overrun;
  assign rx_start_n = r_start_n;

endmodule
